// File: rtl/awaddr_wr_resp.sv
// AXI4-Lite write responder: collects AW and W independently, then either
// updates the control register, pushes one word into the write FIFO, or answers SLVERR.
module awaddr_wr_resp #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] CTRL_ADDR  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] WFIFO_ADDR = 32'h0000_0010
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic                fifo_full,
    output logic                fifo_wr_en,
    output logic [DATA_W-1:0]   fifo_wr_data,
    output logic [DATA_W-1:0]   ctrl_reg,
    output logic                ctrl_wr_pulse
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                aw_held_q, aw_held_d;
    logic                w_held_q, w_held_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                fifo_wr_en_q, fifo_wr_en_d;
    logic [DATA_W-1:0]   fifo_wr_data_q, fifo_wr_data_d;
    logic [DATA_W-1:0]   ctrl_reg_q, ctrl_reg_d;
    logic                ctrl_wr_pulse_q, ctrl_wr_pulse_d;

    assign AWREADY       = awready_q;
    assign WREADY        = wready_q;
    assign BVALID        = bvalid_q;
    assign BRESP         = bresp_q;
    assign fifo_wr_en    = fifo_wr_en_q;
    assign fifo_wr_data  = fifo_wr_data_q;
    assign ctrl_reg      = ctrl_reg_q;
    assign ctrl_wr_pulse = ctrl_wr_pulse_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q         <= S_IDLE;
            aw_held_q       <= 1'b0;
            w_held_q        <= 1'b0;
            awaddr_q        <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            awready_q       <= 1'b0;
            wready_q        <= 1'b0;
            bvalid_q        <= 1'b0;
            bresp_q         <= RESP_OKAY;
            fifo_wr_en_q    <= 1'b0;
            fifo_wr_data_q  <= '0;
            ctrl_reg_q      <= '0;
            ctrl_wr_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            aw_held_q       <= aw_held_d;
            w_held_q        <= w_held_d;
            awaddr_q        <= awaddr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            awready_q       <= awready_d;
            wready_q        <= wready_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            fifo_wr_en_q    <= fifo_wr_en_d;
            fifo_wr_data_q  <= fifo_wr_data_d;
            ctrl_reg_q      <= ctrl_reg_d;
            ctrl_wr_pulse_q <= ctrl_wr_pulse_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        aw_held_d       = aw_held_q;
        w_held_d        = w_held_q;
        awaddr_d        = awaddr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        bvalid_d        = bvalid_q;
        bresp_d         = bresp_q;
        fifo_wr_en_d    = 1'b0;
        fifo_wr_data_d  = fifo_wr_data_q;
        ctrl_reg_d      = ctrl_reg_q;
        ctrl_wr_pulse_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (AWVALID && awready_q) begin
                    awaddr_d  = AWADDR;
                    aw_held_d = 1'b1;
                end
                if (WVALID && wready_q) begin
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                    w_held_d = 1'b1;
                end
                if (aw_held_q && w_held_q) begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (awaddr_q == CTRL_ADDR) begin
                    for (int unsigned i = 0; i < STRB_W; i++) begin
                        if (wstrb_q[i]) begin
                            ctrl_reg_d[i*8 +: 8] = wdata_q[i*8 +: 8];
                        end
                    end
                    ctrl_wr_pulse_d = 1'b1;
                    bresp_d         = RESP_OKAY;
                    bvalid_d        = 1'b1;
                    state_d         = S_RESP;
                end else if (awaddr_q == WFIFO_ADDR && wstrb_q == '1) begin
                    // A full FIFO stalls the whole channel here until space appears
                    if (!fifo_full) begin
                        fifo_wr_en_d   = 1'b1;
                        fifo_wr_data_d = wdata_q;
                        bresp_d        = RESP_OKAY;
                        bvalid_d       = 1'b1;
                        state_d        = S_RESP;
                    end
                end else begin
                    bresp_d  = RESP_SLVERR;
                    bvalid_d = 1'b1;
                    state_d  = S_RESP;
                end
            end

            S_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Ready flags are registered copies of the next-state decode
        awready_d = (state_d == S_IDLE) && !aw_held_d;
        wready_d  = (state_d == S_IDLE) && !w_held_d;
    end

endmodule

// File: tb/tb_awaddr_wr_resp.sv
// Self-checking bench for awaddr_wr_resp: directed scenarios plus randomized
// writes compared against a transaction-level model of ctrl_reg and the FIFO.
module tb_awaddr_wr_resp;

    localparam logic [31:0] A_CTRL  = 32'h0000_0000;
    localparam logic [31:0] A_WFIFO = 32'h0000_0010;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic [31:0] ctrl_reg;
    logic        ctrl_wr_pulse;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_ctrl;
    logic [31:0] m_fdata;
    int unsigned cyc_cnt = 0;
    int unsigned last_bv_cyc;

    awaddr_wr_resp #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .CTRL_ADDR (A_CTRL),
        .WFIFO_ADDR(A_WFIFO)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .AWADDR       (AWADDR),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WDATA        (WDATA),
        .WSTRB        (WSTRB),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .BRESP        (BRESP),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .ctrl_reg     (ctrl_reg),
        .ctrl_wr_pulse(ctrl_wr_pulse)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1);
    end

    // Drives AW and W with independent delays; returns one tick after the later handshake edge.
    task automatic handshake(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             output bit ok);
        int c;
        bit aw_done, w_done, aw_fire, w_fire;
        c = 0; aw_done = 0; w_done = 0; ok = 1;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        while (!(aw_done && w_done)) begin
            if (c >= 100) begin
                checks++; errors++;
                $display("FAIL handshake_timeout: aw_done=%0d w_done=%0d after %0d cycles, need both", aw_done, w_done, c);
                AWVALID = 1'b0; WVALID = 1'b0; ok = 0;
                return;
            end
            AWVALID = !aw_done && (c >= aw_dly);
            WVALID  = !w_done && (c >= w_dly);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge ACLK); #1; c++;
            if (aw_fire) begin aw_done = 1; AWVALID = 1'b0; end
            if (w_fire)  begin w_done = 1;  WVALID = 1'b0;  end
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int full_cyc, input int bready_dly, input bit hold_aw);
        bit          ok, is_ctrl, push;
        logic [1:0]  exp_resp;
        logic [31:0] mask;
        int          exp_stall;
        is_ctrl   = (addr == A_CTRL);
        push      = !is_ctrl && (addr == A_WFIFO) && (strb == 4'hF);
        exp_resp  = (is_ctrl || push) ? 2'b00 : 2'b10;
        exp_stall = push ? full_cyc : 0;
        mask = '0;
        for (int b = 0; b < 4; b++)
            if (strb[b]) mask = mask | (32'hFF << (8 * b));

        fifo_full = (full_cyc > 0);
        BREADY    = (bready_dly == 0);
        handshake(addr, data, strb, aw_dly, w_dly, ok);
        if (!ok) return;

        checks++;
        if (BVALID !== 1'b0) begin
            errors++; $display("FAIL %s early_bvalid: BVALID=%b right after handshake, need 0", tag, BVALID);
        end
        @(posedge ACLK); #1;
        checks++;
        if ({BVALID, AWREADY, WREADY, fifo_wr_en, ctrl_wr_pulse} !== 5'b0) begin
            errors++; $display("FAIL %s exec_cycle: BV/AWR/WR/push/pulse=%b, need 00000", tag,
                               {BVALID, AWREADY, WREADY, fifo_wr_en, ctrl_wr_pulse});
        end
        for (int k = 0; k < exp_stall; k++) begin
            @(posedge ACLK); #1;
            checks++;
            if ({BVALID, AWREADY, WREADY, fifo_wr_en, ctrl_wr_pulse} !== 5'b0) begin
                errors++; $display("FAIL %s full_stall%0d: BV/AWR/WR/push/pulse=%b, need 00000", tag, k,
                                   {BVALID, AWREADY, WREADY, fifo_wr_en, ctrl_wr_pulse});
            end
        end
        fifo_full = 1'b0;

        if (push) m_fdata = data;
        if (is_ctrl) m_ctrl = (m_ctrl & ~mask) | (data & mask);

        @(posedge ACLK); #1;
        last_bv_cyc = cyc_cnt;
        checks++;
        if (BVALID !== 1'b1 || BRESP !== exp_resp) begin
            errors++; $display("FAIL %s response: BVALID=%b BRESP=%b, need 1 %b", tag, BVALID, BRESP, exp_resp);
        end
        checks++;
        if (fifo_wr_en !== push || ctrl_wr_pulse !== is_ctrl) begin
            errors++; $display("FAIL %s strobes: fifo_wr_en=%b ctrl_wr_pulse=%b, need %b %b", tag,
                               fifo_wr_en, ctrl_wr_pulse, push, is_ctrl);
        end
        checks++;
        if (fifo_wr_data !== m_fdata || ctrl_reg !== m_ctrl) begin
            errors++; $display("FAIL %s data: fifo_wr_data=%h ctrl_reg=%h, need %h %h", tag,
                               fifo_wr_data, ctrl_reg, m_fdata, m_ctrl);
        end

        for (int k = 0; k < bready_dly; k++) begin
            if (hold_aw) begin AWVALID = 1'b1; AWADDR = ~addr; end
            @(posedge ACLK); #1;
            checks++;
            if (BVALID !== 1'b1 || BRESP !== exp_resp || AWREADY !== 1'b0 || WREADY !== 1'b0 ||
                fifo_wr_en !== 1'b0 || ctrl_wr_pulse !== 1'b0 || ctrl_reg !== m_ctrl) begin
                errors++; $display("FAIL %s bhold%0d: BV=%b BR=%b AWR=%b WR=%b push=%b pulse=%b ctrl=%h, need 1 %b 0 0 0 0 %h",
                                   tag, k, BVALID, BRESP, AWREADY, WREADY, fifo_wr_en, ctrl_wr_pulse, ctrl_reg,
                                   exp_resp, m_ctrl);
            end
        end
        AWVALID = 1'b0;
        BREADY  = 1'b1;
        @(posedge ACLK); #1;
        checks++;
        if ({BVALID, AWREADY, WREADY, fifo_wr_en, ctrl_wr_pulse} !== 5'b01100) begin
            errors++; $display("FAIL %s after_b: BV/AWR/WR/push/pulse=%b, need 01100", tag,
                               {BVALID, AWREADY, WREADY, fifo_wr_en, ctrl_wr_pulse});
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b1; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b1; fifo_full = 1'b0;
        #3 ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        m_ctrl = '0; m_fdata = '0;
        checks++;
        if ({AWREADY, WREADY, BVALID, BRESP, fifo_wr_en, ctrl_wr_pulse} !== 7'b0 ||
            fifo_wr_data !== 32'h0 || ctrl_reg !== 32'h0) begin
            errors++; $display("FAIL reset_state: AWR=%b WR=%b BV=%b BR=%b push=%b pulse=%b fdata=%h ctrl=%h, need all 0",
                               AWREADY, WREADY, BVALID, BRESP, fifo_wr_en, ctrl_wr_pulse, fifo_wr_data, ctrl_reg);
        end
        #2 ARESETn = 1'b1;
        @(posedge ACLK); #1;
        checks++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: AWREADY=%b WREADY=%b, need 1 1", AWREADY, WREADY);
        end
    endtask

    task automatic test_fifo_push();
        do_write("fifo_push", A_WFIFO, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    endtask

    task automatic test_ctrl_strobe();
        do_write("ctrl_strobe", A_CTRL, 32'h12345678, 4'h5, 3, 0, 0, 0, 0);
        checks++;
        if (ctrl_reg !== 32'h00340078) begin
            errors++; $display("FAIL ctrl_strobe_value: ctrl_reg=%h, need 00340078", ctrl_reg);
        end
    endtask

    task automatic test_slverr();
        do_write("slverr_addr", 32'h0000_0020, 32'hCAFEF00D, 4'hF, 1, 2, 0, 0, 0);
        do_write("slverr_strb", A_WFIFO, 32'h0BADF00D, 4'h7, 0, 0, 0, 0, 0);
    endtask

    task automatic test_fifo_full();
        do_write("fifo_full", A_WFIFO, 32'hA5A5_5A5A, 4'hF, 0, 1, 5, 0, 0);
    endtask

    task automatic test_bready_hold();
        do_write("bready_hold", A_CTRL, 32'hFFFF_0000, 4'hC, 0, 0, 0, 4, 1);
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_write("pre_reset", A_CTRL, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0);
        fifo_full = 1'b1;
        handshake(A_WFIFO, 32'h1111_2222, 4'hF, 0, 0, ok);
        repeat (2) @(posedge ACLK);
        #3 ARESETn = 1'b0;
        #1;
        fifo_full = 1'b0;
        m_ctrl = '0; m_fdata = '0;
        checks++;
        if ({AWREADY, WREADY, BVALID, BRESP, fifo_wr_en, ctrl_wr_pulse} !== 7'b0 ||
            fifo_wr_data !== 32'h0 || ctrl_reg !== 32'h0) begin
            errors++; $display("FAIL reset_mid_state: AWR=%b WR=%b BV=%b BR=%b push=%b pulse=%b fdata=%h ctrl=%h, need all 0",
                               AWREADY, WREADY, BVALID, BRESP, fifo_wr_en, ctrl_wr_pulse, fifo_wr_data, ctrl_reg);
        end
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge ACLK); #1;
            checks++;
            if (fifo_wr_en !== 1'b0 || BVALID !== 1'b0 || ctrl_reg !== 32'h0) begin
                errors++; $display("FAIL reset_mid_abort%0d: push=%b BV=%b ctrl=%h, need 0 0 0", k,
                                   fifo_wr_en, BVALID, ctrl_reg);
            end
        end
        do_write("post_reset", A_WFIFO, 32'h3333_4444, 4'hF, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] addr, data;
        logic [3:0]  strb;
        int          fc;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       addr = A_CTRL;
                1, 2:    addr = A_WFIFO;
                default: addr = $urandom;
            endcase
            data = $urandom;
            strb = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            fc   = (strb == 4'hF) ? int'($urandom_range(0, 3)) : 0;
            do_write("random", addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     fc, int'($urandom_range(0, 2)), $urandom_range(0, 1) != 0);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned prev;
        do_write("b2b", A_WFIFO, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0);
        prev = last_bv_cyc;
        for (int n = 0; n < 3; n++) begin
            do_write("b2b", (n == 1) ? A_CTRL : A_WFIFO, 32'h1000_0000 + n, 4'hF, 0, 0, 0, 0, 0);
            checks++;
            if (last_bv_cyc - prev != 4) begin
                errors++; $display("FAIL b2b_spacing: BVALID spacing %0d cycles, need 4", last_bv_cyc - prev);
            end
            prev = last_bv_cyc;
        end
    endtask

    initial begin
        test_reset();
        test_fifo_push();
        test_ctrl_strobe();
        test_slverr();
        test_fifo_full();
        test_bready_hold();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
